// File: rtl/strip_id_lut_seq_if.sv
// Request/response bundle for strip_id_lut_seq: table write port, lookup request, ID beat stream.
interface strip_id_lut_seq_if #(
   parameter int ID_W   = 4,
   parameter int NUM_ID = 3,
   parameter int ADDR_W = 4,
   parameter int RANK_W = (NUM_ID > 1) ? $clog2(NUM_ID) : 1
);
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [NUM_ID*ID_W-1:0] wr_data;
   logic                   req_valid;
   logic                   req_ready;
   logic [ADDR_W-1:0]      req_addr;
   logic                   out_valid;
   logic                   out_ready;
   logic [ID_W-1:0]        out_id;
   logic [RANK_W-1:0]      out_rank;
   logic                   out_last;
   logic                   out_none;
   logic                   out_err;

   modport master (
      output wr_en, wr_addr, wr_data, req_valid, req_addr, out_ready,
      input  req_ready, out_valid, out_id, out_rank, out_last, out_none, out_err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, req_valid, req_addr, out_ready,
      output req_ready, out_valid, out_id, out_rank, out_last, out_none, out_err
   );
endinterface

// File: rtl/strip_id_lut_seq.sv
// Strip-ID lookup table: one request streams the nonzero IDs of an entry, slot 0 first.
// Latency 2 cycles accept-to-first-beat; out_ready=0 holds the beat, one request in flight at a time.
module strip_id_lut_seq #(
   parameter int ID_W   = 4,
   parameter int NUM_ID = 3,
   parameter int DEPTH  = 10,
   parameter int ADDR_W = 4,
   localparam int RANK_W = (NUM_ID > 1) ? $clog2(NUM_ID) : 1
) (
   input logic               clk,
   input logic               rst,
   strip_id_lut_seq_if.slave bus
);
   localparam int E_W   = NUM_ID * ID_W;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic [E_W-1:0]    snap_q, snap_d;
   logic [NUM_ID-1:0] mask_q, mask_d;
   logic [E_W-1:0]    table_q [DEPTH];

   logic              addr_ok, wr_ok, cur_last;
   logic [RANK_W-1:0] sel;
   logic [ID_W-1:0]   cur_id;
   logic [NUM_ID-1:0] sel_oh;

   function automatic logic [E_W-1:0] init_entry(input int k);
      logic [11:0] v;
      v = 12'h000;
      case (k)
         0: v = 12'hA80;
         1: v = 12'h860;
         2: v = 12'h640;
         3: v = 12'h412;
         4: v = 12'h123;
         5: v = 12'h350;
         6: v = 12'h570;
         7: v = 12'h790;
         8: v = 12'h900;
         9: v = 12'hBCD;
         default: v = 12'h000;
      endcase
      if (ID_W == 4 && NUM_ID == 3) return E_W'(v);
      return '0;
   endfunction

   assign addr_ok = int'(addr_q) < DEPTH;
   assign wr_ok   = int'(bus.wr_addr) < DEPTH;

   // Lowest remaining slot is the current beat; it is last if no higher slot remains.
   always_comb begin
      sel    = '0;
      cur_id = '0;
      for (int k = NUM_ID - 1; k >= 0; k--) begin
         if (mask_q[k]) sel = RANK_W'(k);
      end
      for (int k = 0; k < NUM_ID; k++) begin
         if (mask_q[k] && RANK_W'(k) == sel) cur_id = snap_q[(NUM_ID-k)*ID_W-1 -: ID_W];
      end
      sel_oh   = NUM_ID'(1) << sel;
      cur_last = (mask_q & ~sel_oh) == '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         err_q   <= 1'b0;
         snap_q  <= '0;
         mask_q  <= '0;
         for (int i = 0; i < DEPTH; i++) table_q[i] <= init_entry(i);
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         snap_q  <= snap_d;
         mask_q  <= mask_d;
         if (bus.wr_en && wr_ok) table_q[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      err_d         = err_q;
      snap_d        = snap_q;
      mask_d        = mask_q;
      bus.req_ready = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_id    = '0;
      bus.out_rank  = '0;
      bus.out_last  = 1'b0;
      bus.out_none  = 1'b0;
      bus.out_err   = 1'b0;
      case (state_q)
         IDLE: begin
            bus.req_ready = !rst;
            if (bus.req_valid && !rst) begin
               addr_d  = bus.req_addr;
               state_d = FETCH;
            end
         end
         FETCH: begin
            err_d  = !addr_ok;
            snap_d = '0;
            mask_d = '0;
            if (addr_ok) begin
               snap_d = table_q[addr_q[IDX_W-1:0]];
               for (int k = 0; k < NUM_ID; k++) begin
                  mask_d[k] = |snap_d[(NUM_ID-k)*ID_W-1 -: ID_W];
               end
            end
            state_d = EMIT;
         end
         EMIT: begin
            // An empty mask (or bad address) still yields one terminating beat.
            bus.out_valid = !rst;
            bus.out_id    = cur_id;
            bus.out_rank  = (mask_q == '0) ? '0 : sel;
            bus.out_last  = cur_last;
            bus.out_none  = (mask_q == '0);
            bus.out_err   = err_q;
            if (bus.out_ready) begin
               mask_d = mask_q & ~sel_oh;
               if (cur_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_strip_id_lut_seq.sv
// Scoreboard bench for strip_id_lut_seq: expected beats queued at request, popped on handshake.
module tb_strip_id_lut_seq;
   localparam int ID_W   = 4;
   localparam int NUM_ID = 3;
   localparam int DEPTH  = 10;
   localparam int ADDR_W = 4;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] rank;
      logic       last;
      logic       none;
      logic       err;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   strip_id_lut_seq_if #(.ID_W(ID_W), .NUM_ID(NUM_ID), .ADDR_W(ADDR_W)) bus ();
   strip_id_lut_seq #(.ID_W(ID_W), .NUM_ID(NUM_ID), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   beat_t       exp_q[$];
   logic [11:0] model [16];
   int          checks = 0;
   int          failures = 0;
   int          hs_cnt = 0;
   logic        stall = 1'b0;
   beat_t       prev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) model[i] = 12'h000;
      model[0] = 12'hA80; model[1] = 12'h860; model[2] = 12'h640; model[3] = 12'h412;
      model[4] = 12'h123; model[5] = 12'h350; model[6] = 12'h570; model[7] = 12'h790;
      model[8] = 12'h900; model[9] = 12'hBCD;
   endfunction

   function automatic void push_expect(input int a);
      beat_t       b;
      logic [11:0] e;
      logic [3:0]  s;
      int          last_k;
      if (a >= DEPTH) begin
         b = '{id: 4'h0, rank: 2'd0, last: 1'b1, none: 1'b1, err: 1'b1};
         exp_q.push_back(b);
         return;
      end
      e = model[a];
      last_k = -1;
      for (int k = 0; k < NUM_ID; k++) begin
         s = e[(NUM_ID-k)*ID_W-1 -: ID_W];
         if (s != 4'h0) last_k = k;
      end
      if (last_k < 0) begin
         b = '{id: 4'h0, rank: 2'd0, last: 1'b1, none: 1'b1, err: 1'b0};
         exp_q.push_back(b);
         return;
      end
      for (int k = 0; k < NUM_ID; k++) begin
         s = e[(NUM_ID-k)*ID_W-1 -: ID_W];
         if (s != 4'h0) begin
            b = '{id: s, rank: 2'(k), last: (k == last_k), none: 1'b0, err: 1'b0};
            exp_q.push_back(b);
         end
      end
   endfunction

   task automatic wr(input logic [3:0] a, input logic [11:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      if (a < DEPTH) model[a] = d;
   endtask

   task automatic send_req(input logic [3:0] a);
      int n;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_before_send", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      push_expect(int'(a));
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 20);
      chk("first_beat_latency", 32'(n), 2);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !bus.req_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue", 32'(exp_q.size()), 0);
   endtask

   // Beat monitor: scoreboard on handshake, stability while stalled.
   initial begin
      beat_t cur, e;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 1'b0;
         end else begin
            cur = '{id: bus.out_id, rank: bus.out_rank, last: bus.out_last,
                    none: bus.out_none, err: bus.out_err};
            if (stall) begin
               chk("hold_valid", 32'(bus.out_valid), 1);
               chk("hold_beat", 32'(cur), 32'(prev));
            end
            if (bus.out_valid) begin
               if (bus.out_ready) begin
                  hs_cnt++;
                  stall = 1'b0;
                  if (exp_q.size() == 0) begin
                     chk("unexpected_beat", 32'(cur), 0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("beat_id", 32'(cur.id), 32'(e.id));
                     chk("beat_rank", 32'(cur.rank), 32'(e.rank));
                     chk("beat_last", 32'(cur.last), 32'(e.last));
                     chk("beat_none", 32'(cur.none), 32'(e.none));
                     chk("beat_err", 32'(cur.err), 32'(e.err));
                  end
               end else begin
                  stall = 1'b1;
                  prev  = cur;
               end
            end else begin
               stall = 1'b0;
            end
         end
      end
   end

   initial begin
      int h0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_flags", {28'h0, bus.out_last, bus.out_none, bus.out_err, 1'b0}, 0);
      chk("rst_out_id_rank", {26'h0, bus.out_id, bus.out_rank}, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_req_ready", 32'(bus.req_ready), 1);

      send_req(4'd3); wait_idle();
      send_req(4'd0); wait_idle();
      send_req(4'd8); wait_idle();

      bus.out_ready = 1'b0;
      h0 = hs_cnt;
      send_req(4'd9);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      wait_idle();
      chk("bp_handshakes", 32'(hs_cnt - h0), 3);

      send_req(4'd12); wait_idle();
      chk("idle_after_err", 32'(bus.req_ready), 1);

      wr(4'd2, 12'h000);
      send_req(4'd2); wait_idle();
      send_req(4'd3);
      wr(4'd3, 12'hFFF);
      wait_idle();
      send_req(4'd3); wait_idle();
      wr(4'd12, 12'h111);

      bus.out_ready = 1'b0;
      send_req(4'd9);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 0);
      chk("midrst_req_ready", 32'(bus.req_ready), 0);
      chk("midrst_out_id", 32'(bus.out_id), 0);
      exp_q.delete();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      send_req(4'd2); wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/strip_id_lut_seq.md
STRIP_ID_LUT_SEQ -- requirements
Module: strip_id_lut_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have parameter ID_W, default 4: width of one strip ID.
REQ-003 The block SHALL have parameter NUM_ID, default 3: ID slots per table entry; slot 0 is most priority.
REQ-004 The block SHALL have parameter DEPTH, default 10: number of table entries.
REQ-005 The block SHALL have parameter ADDR_W, default 4: address width; ADDR_W SHALL be at least clog2(DEPTH).
REQ-006 The block SHALL have derived parameter RANK_W = max(1, clog2(NUM_ID)).
REQ-007 The block SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  write entry index.
- wr_data  in  NUM_ID*ID_W  entry data; slot k at bits [(NUM_ID-k)*ID_W-1 -: ID_W].
- req_valid  in  1  lookup request.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  ADDR_W  lookup entry index (preprocessed height).
- out_valid  out  1  ID beat present.
- out_ready  in  1  consumer accepts beat.
- out_id  out  ID_W  strip ID of current beat.
- out_rank  out  RANK_W  slot index of current beat.
- out_last  out  1  final beat of the response.
- out_none  out  1  response carries no valid ID.
- out_err  out  1  req_addr was >= DEPTH.

Function
REQ-008 The table SHALL hold DEPTH registered entries of NUM_ID*ID_W bits; ID value 0 SHALL mean empty slot.
REQ-009 A write with wr_en=1 and wr_addr<DEPTH SHALL update that entry at the clock edge in any state; a write with wr_addr>=DEPTH SHALL be ignored.
REQ-010 The FSM SHALL have states IDLE, FETCH and EMIT.
REQ-011 req_ready SHALL be 1 exactly when the state is IDLE and rst=0.
REQ-012 In IDLE, req_valid=1 SHALL capture req_addr and move the FSM to FETCH.
REQ-013 FETCH SHALL last one cycle and latch the entry into a snapshot register together with a mask of its nonzero slots.
REQ-014 FETCH SHALL then move the FSM to EMIT.
REQ-015 A write to the same entry on the FETCH edge SHALL NOT appear in the snapshot (read-before-write).
REQ-016 Writes made during EMIT SHALL NOT alter beats in flight.
REQ-017 The first out_valid SHALL occur in the second cycle after the accept edge, giving a 2-cycle latency.
REQ-018 In EMIT, out_valid SHALL be 1 and out_id/out_rank SHALL present the lowest-index remaining nonzero slot.
REQ-019 out_last SHALL be 1 when that slot is the final remaining nonzero slot.
REQ-020 On out_valid and out_ready, the current mask bit SHALL clear; if out_last=1, the FSM SHALL return to IDLE on that edge.
REQ-021 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-022 If the mask is empty, the block SHALL emit a single beat: out_id=0, out_rank=0, out_none=1, out_last=1.
REQ-023 If the captured address is >= DEPTH, the block SHALL emit a single beat: out_err=1, out_none=1, out_id=0, out_last=1, and no table read.
REQ-024 out_none and out_err SHALL be 0 on all other beats.
REQ-025 No new request SHALL be accepted until the last beat handshakes.
REQ-026 The earliest next accept SHALL occur in the cycle after the last-beat handshake.

Reset
REQ-027 While rst=1, the state SHALL be IDLE and out_valid, out_last, out_none, out_err, out_id, out_rank and req_ready SHALL all be 0; the snapshot and mask SHALL be cleared.
REQ-028 Reset SHALL load the table as follows when ID_W=4 and NUM_ID=3: entries 0-9 = A80, 860, 640, 412, 123, 350, 570, 790, 900, BCD (hex); all other entries 0.
REQ-029 For any other ID_W or NUM_ID, reset SHALL load all table entries with 0.
REQ-030 Reset asserted mid-response SHALL drop out_valid immediately and discard the response.

Verification
REQ-031 The bench SHALL cover a default request: after reset, req_addr=3 -> beats (id 4, rank 0), (1, rank 1), (2, rank 2, last); the first beat arrives 2 cycles after accept.
REQ-032 The bench SHALL cover empty-slot skipping: req_addr=0 -> (A, 0), (8, 1, last); req_addr=8 -> single beat (9, 0, last).
REQ-033 The bench SHALL cover backpressure: req_addr=9 with out_ready=0 for 3 cycles -> B held stable, then C, then D (last); exactly 3 handshakes occur.
REQ-034 The bench SHALL cover an out-of-range request: req_addr=12 -> one beat with out_err=1, out_none=1, out_id=0, out_last=1; the FSM then returns to IDLE.
REQ-035 The bench SHALL cover writes: write 000 to entry 2, then req_addr=2 -> one out_none beat; write FFF to entry 3 during EMIT of addr 3 -> in-flight beats remain 4, 1, 2.
REQ-036 The bench SHALL cover reset mid-response: rst pulsed during EMIT -> out_valid=0 within the same cycle, entry 2 restored to 640, and a following req_addr=2 -> 6, 4 (last).
